ssd_scan6: RTL

Reader side of the six-digit BCD bus produced by the clock/stopwatch digit counters (value_0..value_5, 4 bits each). It time-multiplexes the six digits onto a common-anode seven-segment display: digit-select rotation, BCD-to-segment decode, per-frame snapshot (no tearing), leading-zero suppression, blink for set mode and decimal points. It sits between the digit counter block and the board display pins.

---
 rtl/ssd_scan6_pkg.sv | 33 +++
 rtl/ssd_scan6_bcd_to_ssd.sv | 27 ++
 rtl/ssd_scan6.sv | 107 ++++++++++
 3 files changed

// File: rtl/ssd_scan6_pkg.sv
// rtl/ssd_scan6_pkg.sv - shared digit count, glyph constants and segment bit order
package ssd_scan6_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [7:0] seg_t;

  // Active-low segment word, MSB first: bit7=a ... bit1=g, bit0=dp
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic dp;
  } seg_bits_t;

  localparam seg_t SEG_0     = 8'h03;
  localparam seg_t SEG_1     = 8'h9F;
  localparam seg_t SEG_2     = 8'h25;
  localparam seg_t SEG_3     = 8'h0D;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h49;
  localparam seg_t SEG_6     = 8'h41;
  localparam seg_t SEG_7     = 8'h1F;
  localparam seg_t SEG_8     = 8'h01;
  localparam seg_t SEG_9     = 8'h09;
  localparam seg_t SEG_DASH  = 8'hFD;
  localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/ssd_scan6_bcd_to_ssd.sv
// rtl/ssd_scan6_bcd_to_ssd.sv - combinational BCD to active-low seven-segment decoder (dp left off)
module bcd_to_ssd
  import ssd_scan6_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  // Non-BCD codes show a dash so a corrupted counter is visible on the display
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan6.sv
// rtl/ssd_scan6.sv - six-digit multiplexed common-anode display scanner with frame snapshot
module ssd_scan6
  import ssd_scan6_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value_0,
  input  logic [3:0] value_1,
  input  logic [3:0] value_2,
  input  logic [3:0] value_3,
  input  logic [3:0] value_4,
  input  logic [3:0] value_5,
  input  logic [5:0] blink_en,
  input  logic [5:0] dp_mask,
  input  logic       lz_blank,
  output logic [5:0] ssd_ctl,
  output logic [7:0] ssd_out,
  output logic       frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_sel;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic [3:0]       r_snap [NUM_DIGITS];
  logic [5:0]       r_ctl;
  logic [7:0]       r_out;
  logic             r_frame_tick;

  logic             w_scan_tick;
  logic             w_frame_end;
  logic [3:0]       w_values [NUM_DIGITS];
  logic [5:0]       w_ctl;
  seg_t             w_dec;
  seg_bits_t        w_seg;
  logic             w_upper_zero;
  logic             w_blank;

  assign w_values[0] = value_0;
  assign w_values[1] = value_1;
  assign w_values[2] = value_2;
  assign w_values[3] = value_3;
  assign w_values[4] = value_4;
  assign w_values[5] = value_5;

  assign w_scan_tick = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_scan_tick && (r_sel == 3'd5);
  assign w_ctl       = ~(NUM_DIGITS'(1) << r_sel);

  bcd_to_ssd u_dec (
    .i_bcd (r_snap[r_sel]),
    .o_seg (w_dec)
  );

  // A digit is a leading zero when it and every more-significant snapshot digit are 0
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(r_sel)) && (r_snap[j] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_blank = (lz_blank && (r_sel != 3'd0) && w_upper_zero) ||
              (blink_en[r_sel] && r_blink_phase);
    w_seg = seg_bits_t'(w_dec);
    if (dp_mask[r_sel]) w_seg.dp = 1'b0;
    if (w_blank) w_seg = seg_bits_t'(SEG_BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_sel         <= 3'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= 4'd0;
      r_ctl         <= 6'b111111;
      r_out         <= SEG_BLANK;
      r_frame_tick  <= 1'b0;
    end else begin
      r_div_cnt <= w_scan_tick ? '0 : r_div_cnt + 1'b1;
      if (w_scan_tick) r_sel <= (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
      // Snapshot at frame end so a digit never changes partway through a frame
      if (w_frame_end) begin
        r_snap <= w_values;
        if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      r_frame_tick <= w_frame_end;
      r_ctl        <= w_ctl;
      r_out        <= w_seg;
    end
  end

  assign ssd_ctl    = r_ctl;
  assign ssd_out    = r_out;
  assign frame_tick = r_frame_tick;

endmodule
